mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit that sits directly downstream of the register file read ports. It consumes the two source operands (rs, rt) for MULT, MULTU, DIV and DIVU, computes the 64-bit result over 33 cycles, and holds it in the architectural HI/LO registers. MFHI/MFLO read HI/LO, and MTHI/MTLO write them. The control unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits. Only 32 is verified.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin an operation; sampled only when `busy`=0.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `rs_data` in 32: multiplicand or dividend (register file read port 1).
- `rt_data` in 32: multiplier or divisor (register file read port 2).
- `hi_we` in 1: MTHI, load `wr_data` into HI.
- `lo_we` in 1: MTLO, load `wr_data` into LO.
- `wr_data` in 32: data for MTHI/MTLO.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when HI/LO take the new result.
- `hi` out 32: HI register, registered output.
- `lo` out 32: LO register, registered output.

## Operation
- **States:** IDLE, CALC, FIX. `busy` = (state != IDLE).
- **IDLE, on `start`:**
  - Latch `op`.
  - For signed ops, latch the absolute values of the operands, plus sign flags `neg_q` = sign(rs) XOR sign(rt) and `neg_r` = sign(rs).
  - Clear the 64-bit accumulator; set the 5-bit counter to 0; go to CALC.
- **CALC, multiply:** shift-add, one multiplier bit per cycle, LSB first.
- **CALC, divide:** restoring division, one quotient bit per cycle, MSB first.
- **CALC exit:** the counter increments each cycle; after the cycle with counter=31, go to FIX.
- **FIX, multiply:** negate the 64-bit product if signed and `neg_q`. HI = product[63:32], LO = product[31:0].
- **FIX, divide:** LO = quotient, negated if signed and `neg_q`. HI = remainder, negated if signed and `neg_r`.
- **FIX, common:** pulse `done`; go to IDLE.
- **Divide by zero** (`rt_data`=0, any sign): LO = 32'hFFFF_FFFF, HI = `rs_data` as sampled. Same latency; no exception.
- **Signed overflow** 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- **Arithmetic width:** absolute values are 32-bit unsigned, so |−2^31| = 0x8000_0000. All internal negation is two's complement, modulo 2^64 (product) or 2^32 (quotient, remainder).
- **MTHI/MTLO:** honoured only in IDLE. If `start` is high in the same cycle, `start` wins and the writes are dropped. While busy, `hi_we`/`lo_we` are ignored.
- **`start` while busy:** ignored; no queuing.
- **Unchanged state:** HI/LO hold their previous values until FIX or an MTHI/MTLO write.

## Timing
- **Reset (`rst_n`=0, any time, including mid-operation):**
  - state = IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - The in-flight operation is discarded. Outputs change asynchronously.
- **Latency,** with `start` sampled at edge N:
  - `busy`=1 after edge N.
  - CALC occupies edges N+1..N+32; FIX is at edge N+33.
  - After edge N+33: `hi`/`lo` hold the result, `done`=1, `busy`=0.
  - After edge N+34: `done`=0.
- **Back-to-back:** `start` in the cycle where `done`=1 is accepted (state is IDLE). The next result is available 33 cycles later.
- **Operand sampling:** `rs_data`/`rt_data` are sampled only at the start edge. Later changes have no effect.
- **MTHI/MTLO:** visible on `hi`/`lo` one edge after the write.

## Structure
- **Package `mdu_pkg`:** op encodings (`OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`), state enum (IDLE/CALC/FIX), `ITER` = 32.
- **Sub-module `mdu_sign_fix`:** combinational. Takes op, the sign flags, and the raw accumulator; returns the final HI/LO, including the divide-by-zero override. The sequential control and datapath stay in `mult_div_unit`.

## Test plan
- MULT, rs=0xFFFF_FFFD (−3), rt=7 -> after 33 cycles HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. `done` is high for exactly one cycle; `busy` is high for cycles 1..33.
- MULTU, rs=rt=0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001. Back-to-back MULT 5×5, started in the `done` cycle -> HI=0, LO=25 exactly 33 cycles later.
- DIV, rs=0xFFFF_FFF9 (−7), rt=2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- DIVU, rs=100, rt=0 -> LO=0xFFFF_FFFF, HI=100, with normal latency.
- MTHI 0x1234 in IDLE -> `hi`=0x1234 next cycle. `hi_we` pulsed during CALC -> ignored. `start` pulsed during CALC -> ignored; the original result is unaffected.
- DIVU 100/7 started, `rst_n` low at CALC cycle 10 -> immediately `busy`=0, `hi`=`lo`=0. After release, `done` never pulses until a new `start`.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op encodings, FSM states and the iteration count.
package mdu_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the control unit and the MDU.
// master drives operations, slave returns busy/done and HI/LO.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data,
        output hi_we, lo_we, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        input  hi_we, lo_we, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Final sign correction of the raw accumulator into HI/LO.
// Also applies the divide-by-zero result override.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e                op_i,
    input  logic               neg_q_i,
    input  logic               neg_r_i,
    input  logic               div_zero_i,
    input  logic [WIDTH-1:0]   rs_raw_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               sgn;

    // Pick product or quotient/remainder and restore signs.
    always_comb begin
        sgn  = op_is_signed(op_i);
        prod = acc_i;
        quo  = acc_i[WIDTH-1:0];
        rem  = acc_i[2*WIDTH-1:WIDTH];
        if (sgn && neg_q_i) begin
            prod = -acc_i;
            quo  = -acc_i[WIDTH-1:0];
        end
        if (sgn && neg_r_i) begin
            rem = -acc_i[2*WIDTH-1:WIDTH];
        end
        if (!op_is_div(op_i)) begin
            hi_o = prod[2*WIDTH-1:WIDTH];
            lo_o = prod[WIDTH-1:0];
        end else if (div_zero_i) begin
            hi_o = rs_raw_i;
            lo_o = '1;
        end else begin
            hi_o = rem;
            lo_o = quo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider.
// Owns the architectural HI/LO registers and MTHI/MTLO writes.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);

    localparam logic [4:0] LAST = 5'(ITER - 1);

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   b_d;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [4:0]         cnt_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic               dz_q;
    logic [WIDTH-1:0]   rs_raw_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    op_e                op_in;
    logic               sgn_in;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [WIDTH:0]     madd;
    logic [WIDTH:0]     dtry;
    logic [WIDTH-1:0]   dsub;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Operand magnitudes and sign flags for the incoming request.
    always_comb begin
        op_in  = op_e'(bus.op);
        sgn_in = op_is_signed(op_in);
        rs_neg = sgn_in & bus.rs_data[WIDTH-1];
        rt_neg = sgn_in & bus.rt_data[WIDTH-1];
        rs_abs = rs_neg ? -bus.rs_data : bus.rs_data;
        rt_abs = rt_neg ? -bus.rt_data : bus.rt_data;
    end

    // One shift-add or restoring-divide step on the accumulator.
    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        madd  = '0;
        dtry  = '0;
        dsub  = '0;
        if (op_is_div(op_q)) begin
            dtry = {acc_q[2*WIDTH-1:WIDTH], b_q[WIDTH-1]};
            dsub = dtry[WIDTH-1:0] - a_q;
            if (dtry >= {1'b0, a_q}) begin
                acc_d = {dsub, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {dtry[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
            b_d = b_q << 1;
        end else begin
            madd = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
            acc_d = {madd, acc_q[WIDTH-1:1]};
            b_d   = b_q >> 1;
        end
    end

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .op_i       (op_q),
        .neg_q_i    (neg_q_q),
        .neg_r_i    (neg_r_q),
        .div_zero_i (dz_q),
        .rs_raw_i   (rs_raw_q),
        .acc_i      (acc_q),
        .hi_o       (fix_hi),
        .lo_o       (fix_lo)
    );

    // Control FSM, datapath registers and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MULTU;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            rs_raw_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= op_in;
                        a_q      <= rt_abs;
                        b_q      <= rs_abs;
                        neg_q_q  <= rs_neg ^ rt_neg;
                        neg_r_q  <= rs_neg;
                        dz_q     <= (bus.rt_data == '0);
                        rs_raw_q <= bus.rs_data;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= CALC;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wr_data;
                        if (bus.lo_we) lo_q <= bus.wr_data;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus
// hand sequences for MTHI/MTLO, busy pokes, reset, back-to-back.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [1:0] op,
                         input logic [31:0] rs,
                         input logic [31:0] rt);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = rs;
        bus.rt_data = rt;
        step();
        cyc = 0;
        bus.start   = 1'b0;
        bus.rs_data = 32'h5A5A_5A5A;
        bus.rt_data = 32'hA5A5_A5A5;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int busy_bad;
        busy_bad = 0;
        while (cyc < 100) begin
            step();
            if (bus.done) break;
            if (!bus.busy) busy_bad++;
        end
        check({name, "_latency"}, cyc, 32'd33);
        check({name, "_busy_gap"}, busy_bad, 32'd0);
        check({name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int dseen;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wr_data = '0;

        vecs[0]  = '{"mult_m3x7",   2'b01, 32'hFFFF_FFFD, 32'd7,
                     32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{"multu_max",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{"mult_5x5",    2'b01, 32'd5, 32'd5,
                     32'd0, 32'd25};
        vecs[3]  = '{"mult_min2",   2'b01, 32'h8000_0000, 32'h8000_0000,
                     32'h4000_0000, 32'd0};
        vecs[4]  = '{"multu_sh4",   2'b00, 32'h1234_5678, 32'h10,
                     32'd1, 32'h2345_6780};
        vecs[5]  = '{"div_m7d2",    2'b11, 32'hFFFF_FFF9, 32'd2,
                     32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{"div_ovf",     2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'd0, 32'h8000_0000};
        vecs[7]  = '{"divu_by0",    2'b10, 32'd100, 32'd0,
                     32'd100, 32'hFFFF_FFFF};
        vecs[8]  = '{"divu_100d7",  2'b10, 32'd100, 32'd7,
                     32'd2, 32'd14};
        vecs[9]  = '{"div_7dm2",    2'b11, 32'd7, 32'hFFFF_FFFE,
                     32'd1, 32'hFFFF_FFFD};
        vecs[10] = '{"div_m100by0", 2'b11, 32'hFFFF_FF9C, 32'd0,
                     32'hFFFF_FF9C, 32'hFFFF_FFFF};
        vecs[11] = '{"divu_maxd1",  2'b10, 32'hFFFF_FFFF, 32'd1,
                     32'd0, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_done(vecs[i].name);
            check({vecs[i].name, "_hi"}, bus.hi, vecs[i].hi);
            check({vecs[i].name, "_lo"}, bus.lo, vecs[i].lo);
            step();
            check({vecs[i].name, "_done_clr"}, {31'd0, bus.done}, 32'd0);
        end

        // MTHI in IDLE
        bus.hi_we   = 1'b1;
        bus.wr_data = 32'h0000_1234;
        step();
        bus.hi_we = 1'b0;
        check("mthi_hi", bus.hi, 32'h0000_1234);
        check("mthi_lo_kept", bus.lo, 32'hFFFF_FFFF);

        // MTLO together with start: write is dropped
        bus.lo_we   = 1'b1;
        bus.wr_data = 32'h0000_0BAD;
        issue(2'b00, 32'd3, 32'd4);
        bus.lo_we = 1'b0;
        check("mtlo_start_drop", bus.lo, 32'hFFFF_FFFF);
        wait_done("multu_3x4");
        check("multu_3x4_hi", bus.hi, 32'd0);
        check("multu_3x4_lo", bus.lo, 32'd12);

        // hi_we and start poked mid-CALC are ignored
        issue(2'b10, 32'd100, 32'd7);
        repeat (4) step();
        bus.hi_we   = 1'b1;
        bus.wr_data = 32'hDEAD_BEEF;
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.rs_data = 32'd9;
        bus.rt_data = 32'd9;
        step();
        bus.hi_we = 1'b0;
        bus.start = 1'b0;
        check("busy_hi_we_ignored", bus.hi, 32'd0);
        wait_done("poke_divu");
        check("poke_divu_hi", bus.hi, 32'd2);
        check("poke_divu_lo", bus.lo, 32'd14);
        step();

        // asynchronous reset mid-CALC
        issue(2'b10, 32'd100, 32'd7);
        while (cyc < 10) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dseen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.done || bus.busy) dseen++;
        end
        check("midrst_no_done", dseen, 32'd0);

        // back-to-back: second start in the done cycle
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("b2b_first");
        check("b2b_first_hi", bus.hi, 32'hFFFF_FFFE);
        check("b2b_first_lo", bus.lo, 32'h0000_0001);
        issue(2'b01, 32'd5, 32'd5);
        wait_done("b2b_second");
        check("b2b_second_hi", bus.hi, 32'd0);
        check("b2b_second_lo", bus.lo, 32'd25);
        step();
        check("b2b_done_clr", {31'd0, bus.done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
